iob_eth_csr_responder: RTL

IOb-native bus responder implementing the Ethernet MAC control/status register bank and buffer-descriptor (BD) RAM. It is the target side of the valid/address/wdata/wstrb to ready/rdata transactions that CPU firmware and the ethmac testbenches issue. It is used as a standalone CSR model in simulation and as the CSR/BD front end in the ethmac wrapper. Interrupt events from the MAC core set sticky source bits, and a masked interrupt line is produced.

---
 rtl/iob_eth_csr_responder.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/iob_eth_csr_responder.sv
// ---------------------------------------------------------------------------
// iob_eth_csr_responder
//
// IOb-native bus target holding the Ethernet MAC control/status registers
// (MODER, INT_SOURCE, INT_MASK) and the buffer-descriptor RAM. MAC event
// pulses set sticky INT_SOURCE bits; the masked OR drives a registered
// interrupt line.
//
// Ports:
//   clk_i              system clock
//   arst_i             synchronous active-high reset
//   valid              one-cycle request strobe
//   address            byte address (bits [1:0] and above bit 10 ignored)
//   wdata / wstrb      write data / byte enables (wstrb == 0 means read)
//   rdata / ready      one-cycle response; rdata is 0 whenever ready is 0
//   int_evt_i          MAC event pulses (TXB,TXE,RXB,RXE,BUSY,TXC,RXC)
//   moder_o            current MODER value towards the MAC core
//   ethernet_interrupt registered OR of (INT_SOURCE & INT_MASK)
//
// Optional feature macro: IOB_ETH_CSR_BUSERR_EN
//   When defined, a read-only BUSERR register at 0x0C counts requests that
//   were dropped while busy (bits 15:0) and unmapped accesses (bits 31:16),
//   both saturating; any write to 0x0C clears both counts.
// ---------------------------------------------------------------------------
module iob_eth_csr_responder #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 0,
  parameter int BD_DEPTH    = 256
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  input  logic [6:0]          int_evt_i,
  output logic [16:0]         moder_o,
  output logic                ethernet_interrupt
);

  localparam int          BD_AW     = $clog2(BD_DEPTH);
  localparam logic [16:0] MODER_RST = 17'h0A000;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        wait_cnt;

  logic [16:0]       moder;
  logic [6:0]        int_source;
  logic [6:0]        int_mask;
  logic [DATA_W-1:0] bd_mem [BD_DEPTH];
  logic [DATA_W-1:0] resp_data;

  logic              accept;
  logic              is_write;
  logic              sel_bd, sel_moder, sel_isrc, sel_imask, sel_buserr;
  logic              unmapped;
  logic [BD_AW-1:0]  bd_idx;
  logic [DATA_W-1:0] bmask;
  logic [DATA_W-1:0] bd_rd, bd_wr;
  logic [16:0]       moder_nxt;
  logic [6:0]        imask_nxt;
  logic [6:0]        isrc_clr, isrc_nxt;
  logic [DATA_W-1:0] resp_nxt;
  logic              unused_addr;

`ifdef IOB_ETH_CSR_BUSERR_EN
  logic [15:0]       busy_cnt;
  logic [15:0]       unmap_cnt;
  logic              dropped;
`endif

  // Only part of the address is decoded; fold the rest into a sink.
  assign unused_addr = ^address;

  // Expand byte enables into a bit mask shared by every writable target.
  always_comb begin
    bmask = '0;
    for (int b = 0; b < DATA_W/8; b++) begin
      bmask[8*b +: 8] = {8{wstrb[b]}};
    end
  end

  // A request is only taken in IDLE; anything arriving later is dropped.
  assign accept    = valid && (state == ST_IDLE);
  assign is_write  = |wstrb;
  assign sel_bd    = address[10];
  assign sel_moder = !address[10] && (address[9:2] == 8'd0);
  assign sel_isrc  = !address[10] && (address[9:2] == 8'd1);
  assign sel_imask = !address[10] && (address[9:2] == 8'd2);
`ifdef IOB_ETH_CSR_BUSERR_EN
  assign sel_buserr = !address[10] && (address[9:2] == 8'd3);
`else
  assign sel_buserr = 1'b0;
`endif
  assign unmapped  = !(sel_bd | sel_moder | sel_isrc | sel_imask | sel_buserr);

  assign bd_idx    = address[BD_AW+1:2];
  assign bd_rd     = bd_mem[bd_idx];
  assign bd_wr     = (bd_rd & ~bmask) | (wdata & bmask);

  assign moder_nxt = (accept && is_write && sel_moder)
                   ? ((moder & ~bmask[16:0]) | (wdata[16:0] & bmask[16:0]))
                   : moder;
  assign imask_nxt = (accept && is_write && sel_imask)
                   ? ((int_mask & ~bmask[6:0]) | (wdata[6:0] & bmask[6:0]))
                   : int_mask;

  // Set has priority over write-1-to-clear on the same bit.
  assign isrc_clr  = (accept && sel_isrc && wstrb[0]) ? wdata[6:0] : 7'd0;
  assign isrc_nxt  = (int_source & ~isrc_clr) | int_evt_i;

  // Response word: reads see the current value, writes see the value the
  // target holds after this cycle's update.
  always_comb begin
    resp_nxt = '0;
    if (sel_bd) begin
      resp_nxt = is_write ? bd_wr : bd_rd;
    end else if (sel_moder) begin
      resp_nxt[16:0] = moder_nxt;
    end else if (sel_isrc) begin
      resp_nxt[6:0] = is_write ? isrc_nxt : int_source;
    end else if (sel_imask) begin
      resp_nxt[6:0] = imask_nxt;
`ifdef IOB_ETH_CSR_BUSERR_EN
    end else if (sel_buserr) begin
      resp_nxt = is_write ? '0 : {unmap_cnt, busy_cnt};
`endif
    end
  end

  // State register plus the latency down-counter. The write is committed at
  // acceptance, so only the response word has to be held across WAIT.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wait_cnt <= 4'(WAIT_CYCLES - 1);
      end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // Next-state and response outputs; ready/rdata only live in RESP.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    rdata     = '0;
    case (state)
      ST_IDLE: begin
        if (valid) begin
          state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        ready     = 1'b1;
        rdata     = resp_data;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control/status registers and the registered interrupt line.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      moder              <= MODER_RST;
      int_source         <= '0;
      int_mask           <= '0;
      resp_data          <= '0;
      ethernet_interrupt <= 1'b0;
    end else begin
      moder              <= moder_nxt;
      int_mask           <= imask_nxt;
      int_source         <= isrc_nxt;
      ethernet_interrupt <= |(int_source & int_mask);
      if (accept) begin
        resp_data <= resp_nxt;
      end
    end
  end

  // Descriptor RAM keeps its contents through reset.
  always_ff @(posedge clk_i) begin
    if (!arst_i && accept && is_write && sel_bd) begin
      bd_mem[bd_idx] <= bd_wr;
    end
  end

`ifdef IOB_ETH_CSR_BUSERR_EN
  assign dropped = valid && (state != ST_IDLE);

  // Saturating error counters; a clear beats a simultaneous increment.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      busy_cnt  <= '0;
      unmap_cnt <= '0;
    end else if (accept && is_write && sel_buserr) begin
      busy_cnt  <= '0;
      unmap_cnt <= '0;
    end else begin
      if (dropped && (busy_cnt != 16'hFFFF)) begin
        busy_cnt <= busy_cnt + 16'd1;
      end
      if (accept && unmapped && (unmap_cnt != 16'hFFFF)) begin
        unmap_cnt <= unmap_cnt + 16'd1;
      end
    end
  end
`endif

  assign moder_o = moder;

endmodule
